// File: rtl/mlp_hist_train_ctrl.sv
// Branch-history and training sequencer for the MLP branch predictor.
// Keeps the speculative global history, repairs it on mispredict, and
// queues resolved outcomes for one-per-cycle training strobes.
//
// Issue FSM states:
//   state | meaning
//   IDLE  | no strobe this cycle; train outputs hold last values
//   ISSUE | train_en high; train outputs carry the entry popped last cycle
module mlp_hist_train_ctrl #(
  parameter int FEATURES = 32,
  parameter int DEPTH    = 4,
  parameter int CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pred_valid,
  input  logic                    pred_taken,
  output logic [FEATURES-1:0]     predict_features,
  input  logic                    res_valid,
  input  logic [31:0]             res_pc,
  input  logic [FEATURES-1:0]     res_features,
  input  logic                    res_taken,
  input  logic                    res_mispredict,
  input  logic                    train_hold,
  output logic                    train_en,
  output logic [31:0]             train_pc,
  output logic [FEATURES-1:0]     train_features,
  output logic                    actual_taken,
  output logic [$clog2(DEPTH):0]  q_count,
  output logic [CNT_W-1:0]        drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int QC_W  = PTR_W + 1;

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t state, state_next;

  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [31:0]         mem_pc   [DEPTH];
  logic [FEATURES-1:0] mem_feat [DEPTH];
  logic                mem_taken[DEPTH];

  logic full, pop, enq, drop;

  // FIFO handshake; a full FIFO still accepts a write when the head leaves this cycle
  always_comb begin
    full = (q_count == QC_W'(DEPTH));
    pop  = (q_count != '0) && !train_hold;
    enq  = res_valid && (!full || pop);
    drop = res_valid && full && !pop;
  end

  // Speculative history: mispredict repair beats (wrong-path) fetch shifts
  always_ff @(posedge clk) begin
    if (rst) begin
      predict_features <= '0;
    end else if (res_valid && res_mispredict) begin
      predict_features <= {res_features[FEATURES-2:0], res_taken};
    end else if (pred_valid) begin
      predict_features <= {predict_features[FEATURES-2:0], pred_taken};
    end
  end

  // Entry storage; no reset needed since occupancy gates every read
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_pc[wr_ptr]    <= res_pc;
      mem_feat[wr_ptr]  <= res_features;
      mem_taken[wr_ptr] <= res_taken;
    end
  end

  // Pointers, occupancy and saturating drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      q_count  <= '0;
      drop_cnt <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (enq && !pop)      q_count <= q_count + QC_W'(1);
      else if (!enq && pop) q_count <= q_count - QC_W'(1);
      if (drop && (drop_cnt != {CNT_W{1'b1}})) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  // Head entry is captured on pop and shown during the following ISSUE cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      train_pc       <= '0;
      train_features <= '0;
      actual_taken   <= 1'b0;
    end else if (pop) begin
      train_pc       <= mem_pc[rd_ptr];
      train_features <= mem_feat[rd_ptr];
      actual_taken   <= mem_taken[rd_ptr];
    end
  end

  // Issue FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Issue FSM next state and strobe; any pop leads to one ISSUE cycle
  always_comb begin
    state_next = IDLE;
    train_en   = 1'b0;
    case (state)
      IDLE:    state_next = pop ? ISSUE : IDLE;
      ISSUE: begin
        train_en   = 1'b1;
        state_next = pop ? ISSUE : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mlp_hist_train_ctrl.sv
// Bench for mlp_hist_train_ctrl: directed vector table, random traffic
// against a queue-based reference model, and a mid-run reset sequence.
module tb_mlp_hist_train_ctrl;

  localparam int F     = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  localparam logic [31:0] S = 32'h2468ACF1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pred_valid = 1'b0, pred_taken = 1'b0;
  logic res_valid = 1'b0, res_taken = 1'b0, res_mispredict = 1'b0, train_hold = 1'b0;
  logic [31:0] res_pc = '0;
  logic [F-1:0] res_features = '0;
  logic [F-1:0] predict_features, train_features;
  logic train_en, actual_taken;
  logic [31:0] train_pc;
  logic [$clog2(DEPTH):0] q_count;
  logic [CNT_W-1:0] drop_cnt;

  mlp_hist_train_ctrl #(.FEATURES(F), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .predict_features(predict_features),
    .res_valid(res_valid), .res_pc(res_pc), .res_features(res_features),
    .res_taken(res_taken), .res_mispredict(res_mispredict),
    .train_hold(train_hold),
    .train_en(train_en), .train_pc(train_pc), .train_features(train_features),
    .actual_taken(actual_taken), .q_count(q_count), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: the FIFO is a plain queue of resolved entries
  typedef struct packed {
    logic [31:0]  pc;
    logic [F-1:0] feat;
    logic         t;
  } ent_t;

  ent_t         mq[$];
  logic [F-1:0] m_sghr = '0;
  int           m_drop = 0;
  logic         m_ten = 1'b0;
  logic [31:0]  m_tpc = '0;
  logic [F-1:0] m_tfeat = '0;
  logic         m_tt = 1'b0;

  task automatic model_step(input logic r, pv, pt, rv, mis, input logic [31:0] pc,
                            input logic [F-1:0] feat, input logic rt, hold);
    int   sz;
    logic can_pop;
    ent_t e;
    if (r) begin
      m_sghr = '0; mq.delete(); m_drop = 0;
      m_ten = 1'b0; m_tpc = '0; m_tfeat = '0; m_tt = 1'b0;
    end else begin
      sz = mq.size();
      can_pop = (sz > 0) && !hold;
      if (rv && mis)  m_sghr = {feat[F-2:0], rt};
      else if (pv)    m_sghr = {m_sghr[F-2:0], pt};
      m_ten = can_pop;
      if (can_pop) begin
        e = mq.pop_front();
        m_tpc = e.pc; m_tfeat = e.feat; m_tt = e.t;
      end
      if (rv) begin
        if (sz < DEPTH || can_pop) mq.push_back('{pc: pc, feat: feat, t: rt});
        else if (m_drop < (1 << CNT_W) - 1) m_drop++;
      end
    end
  endtask

  // Apply one cycle of inputs, advance the clock, compare against the model
  task automatic step(input logic r, pv, pt, rv, mis, input logic [31:0] pc,
                      input logic [F-1:0] feat, input logic rt, hold);
    rst = r; pred_valid = pv; pred_taken = pt; res_valid = rv; res_mispredict = mis;
    res_pc = pc; res_features = feat; res_taken = rt; train_hold = hold;
    model_step(r, pv, pt, rv, mis, pc, feat, rt, hold);
    @(posedge clk);
    #1;
    chk("m_sghr",   predict_features, m_sghr);
    chk("m_ten",    train_en,         m_ten);
    chk("m_tpc",    train_pc,         m_tpc);
    chk("m_tfeat",  train_features,   m_tfeat);
    chk("m_ttaken", actual_taken,     m_tt);
    chk("m_qcount", q_count,          mq.size());
    chk("m_drop",   drop_cnt,         m_drop);
  endtask

  typedef struct {
    logic r, pv, pt, rv, mis;
    logic [31:0] pc;
    logic [F-1:0] feat;
    logic rt, hold;
    logic [F-1:0] e_sghr;
    logic e_ten;
    logic [31:0] e_tpc;
    int e_qc, e_drop;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, pv, pt, rv, mis, input logic [31:0] pc,
                              input logic [F-1:0] feat, input logic rt, hold,
                              input logic [F-1:0] es, input logic et,
                              input logic [31:0] ep, input int eq, ed);
    vec_t v;
    v.r = r; v.pv = pv; v.pt = pt; v.rv = rv; v.mis = mis; v.pc = pc; v.feat = feat;
    v.rt = rt; v.hold = hold; v.e_sghr = es; v.e_ten = et; v.e_tpc = ep;
    v.e_qc = eq; v.e_drop = ed;
    return v;
  endfunction

  function automatic logic [F-1:0] fz(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0000;
  endfunction

  initial begin
    // reset, then taken pattern 1,0,1,1
    vecs.push_back(mk(1,0,0,0,0, 0,0,0,0,          32'h0,  0, 0, 0, 0));
    vecs.push_back(mk(0,1,1,0,0, 0,0,0,0,          32'h1,  0, 0, 0, 0));
    vecs.push_back(mk(0,1,0,0,0, 0,0,0,0,          32'h2,  0, 0, 0, 0));
    vecs.push_back(mk(0,1,1,0,0, 0,0,0,0,          32'h5,  0, 0, 0, 0));
    vecs.push_back(mk(0,1,1,0,0, 0,0,0,0,          32'hB,  0, 0, 0, 0));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,          32'hB,  0, 0, 0, 0));
    // repair to 0xFFFF0000, then repair colliding with a wrong-path prediction
    vecs.push_back(mk(0,0,0,1,1, 32'h200,32'h7FFF8000,0,0, 32'hFFFF0000, 0, 0, 1, 0));
    vecs.push_back(mk(0,1,0,1,1, 32'h204,32'h12345678,1,0, S, 1, 32'h200, 1, 0));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,          S, 1, 32'h204, 0, 0));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,          S, 0, 32'h204, 0, 0));
    // three back-to-back resolves: strobes at N+2..N+4, low at N+5
    vecs.push_back(mk(0,0,0,1,0, 32'h100,fz(32'h100),1,0, S, 0, 32'h204, 1, 0));
    vecs.push_back(mk(0,0,0,1,0, 32'h104,fz(32'h104),0,0, S, 1, 32'h100, 1, 0));
    vecs.push_back(mk(0,0,0,1,0, 32'h108,fz(32'h108),1,0, S, 1, 32'h104, 1, 0));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,          S, 1, 32'h108, 0, 0));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,          S, 0, 32'h108, 0, 0));
    // held pushes of six: fills to 4, drops 2
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(0,0,0,1,0, 32'h300 + 4*i, fz(32'h300 + 4*i), i[0], 1,
                        S, 0, 32'h108, (i < 4) ? i + 1 : 4, (i < 4) ? 0 : i - 3));
    // release with a 7th push: accepted alongside the pop
    vecs.push_back(mk(0,0,0,1,0, 32'h318,fz(32'h318),1,0, S, 1, 32'h300, 4, 2));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,          S, 1, 32'h304, 3, 2));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,          S, 1, 32'h308, 2, 2));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,          S, 1, 32'h30C, 1, 2));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,          S, 1, 32'h318, 0, 2));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,          S, 0, 32'h318, 0, 2));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].pv, vecs[i].pt, vecs[i].rv, vecs[i].mis, vecs[i].pc,
           vecs[i].feat, vecs[i].rt, vecs[i].hold);
      chk($sformatf("vec%0d_sghr", i), predict_features, vecs[i].e_sghr);
      chk($sformatf("vec%0d_ten", i),  train_en,         vecs[i].e_ten);
      chk($sformatf("vec%0d_tpc", i),  train_pc,         vecs[i].e_tpc);
      chk($sformatf("vec%0d_qc", i),   q_count,          vecs[i].e_qc);
      chk($sformatf("vec%0d_drop", i), drop_cnt,         vecs[i].e_drop);
    end

    // random resolves, mispredicts, predictions and hold toggling
    for (int i = 0; i < 200; i++) begin
      logic rv;
      rv = ($urandom_range(0, 1) == 1);
      step(0, $urandom_range(0, 1), $urandom_range(0, 1), rv,
           rv && ($urandom_range(0, 3) == 0), $urandom & 32'hFFFF_FFFC, $urandom,
           $urandom_range(0, 1), $urandom_range(0, 2) == 0);
    end
    for (int i = 0; i < 8; i++) step(0,0,0,0,0, 0,0,0,0);
    chk("drain_qcount", q_count, 0);

    // reset while three entries are queued; nothing stale may surface afterwards
    for (int i = 0; i < 3; i++) step(0,0,0,1,0, 32'h500 + 4*i, fz(32'h500 + 4*i), 1, 1);
    chk("pre_rst_qcount", q_count, 3);
    step(1,0,0,0,0, 0,0,0,0);
    chk("rst_ten", train_en, 0);
    chk("rst_qcount", q_count, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_sghr", predict_features, 0);
    for (int i = 0; i < 5; i++) begin
      step(0,0,0,0,0, 0,0,0,0);
      chk($sformatf("post_rst_ten%0d", i), train_en, 0);
    end
    step(0,0,0,1,0, 32'hABC, fz(32'hABC), 1, 0);
    step(0,0,0,0,0, 0,0,0,0);
    chk("fresh_ten", train_en, 1);
    chk("fresh_pc", train_pc, 32'hABC);
    step(0,0,0,0,0, 0,0,0,0);
    chk("fresh_end", train_en, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
